// File: rtl/if_fetch_queue.sv
//==============================================================================
// Module      : if_fetch_queue
// Description : Instruction-fetch stage with a DEPTH-entry prefetch queue.
//               Owns the fetch PC, issues in-order requests to instruction
//               memory, pairs each response with its PC and hands {pc, instr}
//               to decode. Redirects flush the queue and squash in-flight
//               responses.
//               Optional feature macro: IF_PERF_CNT_EN (perf counters).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [1:0]      redirect_sel,
  input  logic [XLEN-1:0] alu_target,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_squashed
`endif
);

  localparam int unsigned     c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     c_CW       = $clog2(DEPTH) + 1;
  localparam logic [c_CW:0]   c_DEPTH_S  = (c_CW + 1)'(DEPTH);
  localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);
  localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
  localparam logic [XLEN-1:0] c_STEP     = XLEN'(PC_STEP);

  // Architectural state
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  // PC of the next response that will be kept (oldest non-squashed request)
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [c_CW-1:0] inflight_q, inflight_d;
  logic [c_CW-1:0] drop_q, drop_d;
  logic [c_CW-1:0] count_q, count_d;
  logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [ILEN-1:0] instr_mem_q [DEPTH];

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic [c_CW:0]   w_occ_sum;
  logic            w_req_hs;
  logic            w_rsp;
  logic            w_rsp_drop;
  logic            w_push;
  logic            w_pop;

  assign w_redirect = redirect_valid && (redirect_sel != 2'b00);
  assign w_target   = (redirect_sel == 2'b01) ? alu_target : jump_target;
  assign w_occ_sum  = {1'b0, inflight_q} + {1'b0, count_q};

  assign imem_req_valid = !rst && (w_occ_sum < c_DEPTH_S) && !w_redirect;
  assign imem_req_addr  = fetch_pc_q;

  // A response with nothing outstanding is a memory protocol violation; ignore it
  assign w_req_hs   = imem_req_valid && imem_req_ready;
  assign w_rsp      = imem_rsp_valid && (inflight_q != '0);
  assign w_rsp_drop = w_rsp && ((drop_q != '0) || w_redirect);
  assign w_pop      = (count_q != '0) && out_ready;
  assign w_push     = w_rsp && !w_rsp_drop && ((count_q != c_FULL) || w_pop);

  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_instr = instr_mem_q[rd_ptr_q];

  // Next-state for PCs, counters and queue pointers; redirect overrides sequencing
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + c_CW'(w_req_hs) - c_CW'(w_rsp);
    drop_d     = drop_q;
    count_d    = count_q + c_CW'(w_push) - c_CW'(w_pop);
    rd_ptr_d   = w_pop  ? (rd_ptr_q + c_PTR_ONE) : rd_ptr_q;
    wr_ptr_d   = w_push ? (wr_ptr_q + c_PTR_ONE) : wr_ptr_q;

    if (w_req_hs) begin
      fetch_pc_d = fetch_pc_q + c_STEP;
    end
    if (w_push) begin
      rsp_pc_d = rsp_pc_q + c_STEP;
    end
    if (w_rsp && (drop_q != '0)) begin
      drop_d = drop_q - c_CW'(1);
    end

    if (w_redirect) begin
      // Every request still outstanding after this edge belongs to the old path
      fetch_pc_d = w_target;
      rsp_pc_d   = w_target;
      drop_d     = inflight_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage; cleared on reset so the head reads as zero when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (w_push) begin
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0]     perf_fetched_q;
  logic [31:0]     perf_squashed_q;
  logic [c_CW-1:0] w_flushed;

  // Entries dropped by a flush are those left after an honoured pop
  assign w_flushed = w_redirect ? (count_q - c_CW'(w_pop)) : '0;

  // Fetched / squashed event counters, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q  <= '0;
      perf_squashed_q <= '0;
    end else begin
      perf_fetched_q  <= perf_fetched_q + 32'(w_push);
      perf_squashed_q <= perf_squashed_q + 32'(w_rsp_drop) + 32'(w_flushed);
    end
  end

  assign perf_fetched  = perf_fetched_q;
  assign perf_squashed = perf_squashed_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
//==============================================================================
// Module      : tb_if_fetch_queue
// Description : Self-checking bench for if_fetch_queue with an in-order memory
//               model and a queue-based reference of the fetch stream.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_if_fetch_queue;

  localparam int          DEPTH   = 4;
  localparam int          STEP    = 4;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_sel = 2'b00;
  logic [31:0] alu_target = '0;
  logic [31:0] jump_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  logic        wr_req_valid;
  logic [31:0] wr_req_addr;
  logic        wr_out_valid;
  logic [31:0] wr_out_pc;
  logic [31:0] wr_out_instr;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed;
  logic [31:0] wr_perf_fetched, wr_perf_squashed;
`endif

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC), .PC_STEP(STEP)) u_dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
    .alu_target(alu_target), .jump_target(jump_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
  );

  // Second instance exercising address wrap from the top of the address space
  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC), .PC_STEP(STEP)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .redirect_valid(1'b0), .redirect_sel(2'b00),
    .alu_target(32'h0), .jump_target(32'h0),
    .imem_req_valid(wr_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(wr_req_addr),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .out_valid(wr_out_valid), .out_ready(1'b0),
    .out_pc(wr_out_pc), .out_instr(wr_out_instr)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(wr_perf_fetched), .perf_squashed(wr_perf_squashed)
`endif
  );

  // Reference model: outstanding requests (with squash flag and due cycle)
  // and the expected contents of the decode queue.
  typedef struct {
    logic [31:0] pc;
    bit          stale;
    int          due;
  } req_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        pend[$];
  ent_t        outq[$];
  logic [31:0] exp_pc = RST_PC;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          n_drop = 0;
  int unsigned exp_fetched = 0;
  int unsigned exp_squashed = 0;

  // Values sampled just before the most recent active edge
  bit          s_req_valid, s_rsp, s_pop, s_out_valid, s_w_valid;
  logic [31:0] s_addr, s_out_pc, s_w_addr;

  // One clock cycle: drive inputs, compare DUT against model, advance model
  task automatic cycle(input bit rv, input logic [1:0] sel, input logic [31:0] tgt,
                       input bit rq_rdy, input bit o_rdy, input int lat);
    bit   rd, exp_v, hs, pop;
    req_t r;
    int   due;
    @(negedge clk);
    redirect_valid = rv;
    redirect_sel   = sel;
    alu_target     = (sel == 2'b01) ? tgt : $urandom;
    jump_target    = sel[1] ? tgt : $urandom;
    imem_req_ready = rq_rdy;
    out_ready      = o_rdy;
    imem_rsp_data  = $urandom;
    imem_rsp_valid = !rst && (pend.size() > 0) && (pend[0].due <= cyc);
    #1;
    rd    = rv && (sel != 2'b00);
    exp_v = !rst && (pend.size() + outq.size() < DEPTH) && !rd;

    s_req_valid = imem_req_valid;
    s_addr      = imem_req_addr;
    s_out_valid = out_valid;
    s_out_pc    = out_pc;
    s_rsp       = imem_rsp_valid;
    s_w_valid   = wr_req_valid;
    s_w_addr    = wr_req_addr;

    checks++;
    if (imem_req_valid !== exp_v) begin
      errors++;
      $display("FAIL req_valid cyc=%0d: got %0b expected %0b", cyc, imem_req_valid, exp_v);
    end
    if (exp_v) begin
      checks++;
      if (imem_req_addr !== exp_pc) begin
        errors++;
        $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, imem_req_addr, exp_pc);
      end
    end
    checks++;
    if (out_valid !== (outq.size() > 0)) begin
      errors++;
      $display("FAIL out_valid cyc=%0d: got %0b expected %0b", cyc, out_valid, outq.size() > 0);
    end
    if (outq.size() > 0) begin
      checks++;
      if (out_pc !== outq[0].pc || out_instr !== outq[0].instr) begin
        errors++;
        $display("FAIL out_head cyc=%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                 cyc, out_pc, out_instr, outq[0].pc, outq[0].instr);
      end
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (perf_fetched !== exp_fetched || perf_squashed !== exp_squashed) begin
      errors++;
      $display("FAIL perf cyc=%0d: got fetched=%0d squashed=%0d expected %0d %0d",
               cyc, perf_fetched, perf_squashed, exp_fetched, exp_squashed);
    end
`endif

    pop   = (outq.size() > 0) && o_rdy;
    s_pop = pop;
    if (rst) begin
      pend.delete();
      outq.delete();
      exp_pc       = RST_PC;
      exp_fetched  = 0;
      exp_squashed = 0;
    end else begin
      if (pop) void'(outq.pop_front());
      if (imem_rsp_valid) begin
        r = pend.pop_front();
        if (r.stale || rd) begin
          exp_squashed++;
          n_drop++;
        end else begin
          outq.push_back('{r.pc, imem_rsp_data});
          exp_fetched++;
        end
      end
      hs = exp_v && rq_rdy;
      if (hs) begin
        due = cyc + lat;
        if (pend.size() > 0 && pend[$].due >= due) due = pend[$].due + 1;
        pend.push_back('{exp_pc, 1'b0, due});
        exp_pc = exp_pc + STEP;
      end
      if (rd) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        exp_squashed += outq.size();
        outq.delete();
        exp_pc = tgt;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle(0, 2'b00, 32'h0, 1, 0, 1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(0, 2'b00, 32'h0, 1, 1, 1);
    cycle(0, 2'b00, 32'h0, 1, 1, 1);
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: got v=%0b pc=%h instr=%h expected 0 0 0", out_valid, out_pc, out_instr);
    end
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC) begin
      errors++;
      $display("FAIL reset_req: got v=%0b addr=%h expected 0 %h", imem_req_valid, imem_req_addr, RST_PC);
    end
    checks++;
    if (wr_req_addr !== WRAP_PC) begin
      errors++;
      $display("FAIL reset_wrap_addr: got %h expected %h", wr_req_addr, WRAP_PC);
    end
    rst = 1'b0;
  endtask

  // Latency 1, decode always ready: in-order stream, plus wrap-instance addresses
  task automatic test_stream();
    logic [31:0] nxt = RST_PC;
    logic [31:0] wexp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    bit          seen = 0;
    for (int k = 0; k < 24; k++) begin
      cycle(0, 2'b00, 32'h0, 1, 1, 1);
      if (k < 4) begin
        checks++;
        if (s_w_valid !== 1'b1 || s_w_addr !== wexp[k]) begin
          errors++;
          $display("FAIL wrap_addr k=%0d: got v=%0b addr=%h expected 1 %h", k, s_w_valid, s_w_addr, wexp[k]);
        end
      end else if (k == 4) begin
        checks++;
        if (s_w_valid !== 1'b0) begin
          errors++;
          $display("FAIL wrap_stall: got v=%0b expected 0", s_w_valid);
        end
      end
      if (seen) begin
        checks++;
        if (s_out_valid !== 1'b1 || s_out_pc !== nxt) begin
          errors++;
          $display("FAIL stream k=%0d: got v=%0b pc=%h expected 1 %h", k, s_out_valid, s_out_pc, nxt);
        end
        nxt = nxt + STEP;
      end else if (s_out_valid) begin
        seen = 1;
        checks++;
        if (s_out_pc !== RST_PC) begin
          errors++;
          $display("FAIL stream_first: got pc=%h expected %h", s_out_pc, RST_PC);
        end
        nxt = RST_PC + STEP;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stream_timeout: got no out_valid expected at least one");
    end
  endtask

  // Decode stalled: exactly DEPTH requests, then one pop frees exactly one slot
  task automatic test_backpressure();
    int n_hs = 0;
    pulse_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(0, 2'b00, 32'h0, 1, 0, 1);
      if (s_req_valid) n_hs++;
    end
    checks++;
    if (n_hs != DEPTH || s_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_fill: got %0d requests (last v=%0b) expected %0d (v=0)", n_hs, s_req_valid, DEPTH);
    end
    cycle(0, 2'b00, 32'h0, 1, 1, 1);
    checks++;
    if (s_pop !== 1'b1 || s_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_pop: got pop=%0b v=%0b expected 1 0", s_pop, s_req_valid);
    end
    n_hs = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(0, 2'b00, 32'h0, 1, 0, 1);
      if (k == 0) begin
        checks++;
        if (s_req_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_resume: got v=%0b expected 1", s_req_valid);
        end
      end
      if (s_req_valid) n_hs++;
    end
    checks++;
    if (n_hs != 1) begin
      errors++;
      $display("FAIL bp_single: got %0d requests expected 1", n_hs);
    end
  endtask

  // Latency 3, ALU redirect with two requests in flight
  task automatic test_redirect_inflight();
    int          d0;
    bit          found = 0;
    logic [31:0] sq0;
    pulse_reset();
    cycle(0, 2'b00, 32'h0, 1, 1, 3);
    cycle(0, 2'b00, 32'h0, 1, 1, 3);
    d0  = n_drop;
    sq0 = exp_squashed;
`ifdef IF_PERF_CNT_EN
    sq0 = perf_squashed;
`endif
    cycle(1, 2'b01, 32'h0000_0100, 1, 1, 3);
    cycle(0, 2'b00, 32'h0, 1, 1, 3);
    checks++;
    if (s_req_valid !== 1'b1 || s_addr !== 32'h100 || s_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_next_req: got v=%0b addr=%h ov=%0b expected 1 00000100 0",
               s_req_valid, s_addr, s_out_valid);
    end
    for (int k = 0; k < 10 && !found; k++) begin
      cycle(0, 2'b00, 32'h0, 1, 1, 3);
      if (s_out_valid) begin
        found = 1;
        checks++;
        if (s_out_pc !== 32'h100) begin
          errors++;
          $display("FAIL redir_first_pc: got %h expected 00000100", s_out_pc);
        end
      end
    end
    checks++;
    if (!found || (n_drop - d0) != 2) begin
      errors++;
      $display("FAIL redir_drop: got found=%0b drops=%0d expected 1 2", found, n_drop - d0);
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (perf_squashed - sq0 !== 32'd2) begin
      errors++;
      $display("FAIL redir_perf: got delta %0d expected 2", perf_squashed - sq0);
    end
`endif
  endtask

  // Jump redirect coinciding with a response and a pop
  task automatic test_redirect_rsp_pop();
    int  d0;
    bit  ready_state = 0;
    bit  found = 0;
    pulse_reset();
    for (int k = 0; k < 12 && !ready_state; k++) begin
      cycle(0, 2'b00, 32'h0, 1, 1, 1);
      ready_state = s_out_valid && s_rsp;
    end
    d0 = n_drop;
    cycle(1, 2'b10, 32'h0000_0040, 1, 1, 1);
    checks++;
    if (s_rsp !== 1'b1 || s_pop !== 1'b1) begin
      errors++;
      $display("FAIL rp_setup: got rsp=%0b pop=%0b expected 1 1", s_rsp, s_pop);
    end
    cycle(0, 2'b00, 32'h0, 1, 1, 1);
    checks++;
    if (s_out_valid !== 1'b0 || s_req_valid !== 1'b1 || s_addr !== 32'h40 || (n_drop - d0) != 1) begin
      errors++;
      $display("FAIL rp_after: got ov=%0b v=%0b addr=%h drops=%0d expected 0 1 00000040 1",
               s_out_valid, s_req_valid, s_addr, n_drop - d0);
    end
    for (int k = 0; k < 8 && !found; k++) begin
      cycle(0, 2'b00, 32'h0, 1, 1, 1);
      if (s_out_valid) begin
        found = 1;
        checks++;
        if (s_out_pc !== 32'h40) begin
          errors++;
          $display("FAIL rp_first_pc: got %h expected 00000040", s_out_pc);
        end
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL rp_timeout: got no out_valid expected pc 00000040");
    end
  endtask

  // Memory not ready for 5 cycles: request held stable
  task automatic test_stall();
    logic [31:0] a0;
    pulse_reset();
    for (int k = 0; k < 2; k++) cycle(0, 2'b00, 32'h0, 1, 1, 2);
    cycle(0, 2'b00, 32'h0, 0, 1, 2);
    a0 = s_addr;
    for (int k = 0; k < 5; k++) begin
      cycle(0, 2'b00, 32'h0, 0, 1, 2);
      checks++;
      if (s_req_valid !== 1'b1 || s_addr !== a0 || a0 !== RST_PC + 2 * STEP) begin
        errors++;
        $display("FAIL stall k=%0d: got v=%0b addr=%h expected 1 %h", k, s_req_valid, s_addr, RST_PC + 2 * STEP);
      end
    end
    for (int k = 0; k < 6; k++) cycle(0, 2'b00, 32'h0, 1, 1, 2);
  endtask

  task automatic rand_cycle();
    bit          rv = ($urandom_range(0, 99) < 6);
    logic [1:0]  sel = 2'($urandom_range(0, 3));
    logic [31:0] tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
    cycle(rv, sel, tgt, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60, $urandom_range(1, 4));
  endtask

  // Reset asserted in the middle of traffic
  task automatic test_reset_mid();
    for (int k = 0; k < 30; k++) rand_cycle();
    rst = 1'b1;
    cycle(0, 2'b00, 32'h0, 1, 1, 1);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_req_addr !== RST_PC) begin
      errors++;
      $display("FAIL reset_mid: got ov=%0b addr=%h expected 0 %h", out_valid, imem_req_addr, RST_PC);
    end
    for (int k = 0; k < 10; k++) cycle(0, 2'b00, 32'h0, 1, 1, 1);
  endtask

  // Long random run against the model, with occasional resets
  task automatic test_random();
    int c0 = checks;
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 399) == 0);
      rand_cycle();
    end
    rst = 1'b0;
    cycle(0, 2'b00, 32'h0, 1, 1, 1);
    checks++;
    if (checks - c0 < 3000) begin
      errors++;
      $display("FAIL random_coverage: got %0d comparisons expected at least 3000", checks - c0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_rsp_pop();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage with a decoupled prefetch queue. It sits at the front of the pipeline and owns the fetch PC. It issues in-order requests to instruction memory over a valid/ready handshake and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It delivers {pc, instr} to decode over a valid/ready handshake. Redirects from EX (ALU target) or the jump unit flush the queue and squash in-flight responses.

## Interface
Parameters:
- XLEN, 32, PC/address width
- ILEN, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2; also the maximum number of outstanding requests plus queued entries
- RESET_PC, 32'h0000_0000, first fetch address after reset
- PC_STEP, 4, sequential increment

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- redirect_valid  in  1  redirect request this cycle
- redirect_sel  in  2  01 = alu_target, 10 or 11 = jump_target, 00 = no redirect
- alu_target  in  XLEN  branch target from EX ALU
- jump_target  in  XLEN  jump target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  in-order response valid, always accepted
- imem_rsp_data  in  ILEN  response instruction
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_pc  out  XLEN  PC of head
- out_instr  out  ILEN  instruction of head
- perf_fetched  out  32  only with IF_PERF_CNT_EN
- perf_squashed  out  32  only with IF_PERF_CNT_EN

## Operation
- State: fetch_pc, FIFO of {pc, instr}, `inflight` counter (0..DEPTH), `drop` counter (0..DEPTH), and a small FIFO of request PCs (or an equivalent PC derivation) that pairs each response with its address.
- Request issue: imem_req_valid = !rst && (inflight + occupancy < DEPTH) && !redirect_active. imem_req_addr = fetch_pc.
- On a request handshake, inflight increments and fetch_pc += PC_STEP, truncated mod 2^XLEN. Wrap from all-ones to 0 is legal.
- Response with drop > 0: discarded; drop and inflight both decrement.
- Response with drop == 0: written to the FIFO with its PC; inflight decrements.
- Dequeue: on out_valid && out_ready, the head is popped.
- A simultaneous push and pop on a full or empty queue is legal. Occupancy is unchanged, except empty+push where the pop does not apply.
- Redirect (redirect_valid && redirect_sel != 00):
  - fetch_pc loads the selected target.
  - The FIFO is emptied.
  - drop loads inflight plus any request handshaking that cycle, minus any response arriving that cycle.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle is honoured (decode consumed it), then the flush takes effect.
- redirect_sel == 00 with redirect_valid is ignored.
- Target bits are used unmodified; alignment checking is elsewhere.

## Timing
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC
  - out_valid=0, out_pc=0, out_instr=0
  - inflight=0, drop=0
  - perf counters=0
- First request: cycle after rst deasserts, address RESET_PC.
- Response-to-out_valid latency: 1 cycle (FIFO registered). Out-of-reset to first out_valid is 2 cycles plus memory latency.
- Redirect to new request: imem_req_valid for the target rises the cycle after redirect_valid. out_valid is 0 in that following cycle.
- Redirect has priority over sequential increment in the same cycle.
- Back-pressure: with out_ready=0, issue stops once inflight + occupancy == DEPTH. Issue resumes the cycle after a pop.
- Requests are never dropped while imem_req_valid && !imem_req_ready. Address and valid are held stable until handshake unless a redirect occurs.
- rst mid-operation: all state is cleared next edge. Responses in flight after reset are the memory's responsibility to squash.

## Configuration
- IF_PERF_CNT_EN defined:
  - perf_fetched counts responses written to the FIFO.
  - perf_squashed counts discarded responses plus FIFO entries flushed by redirect.
  - Both are 32-bit, wrap at 2^32, and are cleared by rst.
- IF_PERF_CNT_EN undefined: perf ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, memory latency 1, out_ready=1 → requests at 0x0,0x4,0x8…; out_pc/out_instr stream in order, one per cycle after fill.
- out_ready=0, DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0. One pop → exactly one new request the following cycle.
- Memory latency 3, redirect_sel=01, alu_target=0x100 while 2 requests are in flight → both responses discarded, queue flushed, next request 0x100, first out_pc=0x100. With macro, perf_squashed increments by 2 plus the flushed entry count.
- Redirect in the same cycle as a response and a pop, redirect_sel=10, jump_target=0x40 → popped entry delivered, response discarded, next out_pc=0x40.
- RESET_PC=32'hFFFF_FFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 with no stall.
- imem_req_ready held 0 for 5 cycles → imem_req_addr and imem_req_valid stable throughout. rst asserted mid-stream → out_valid=0 and addr=RESET_PC the next cycle.
